// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_sweep_ctrl
// Description : Frequency-sweep sequencer for the dds core. Steps the freq
//               tuning word from a start value to an inclusive stop value,
//               holding each value for dwell+1 cycles. Supports single-shot,
//               repeating sawtooth and triangle sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
  parameter int W       = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [W-1:0]       cfg_ifreq,
  input  logic [W-1:0]       cfg_f_start,
  input  logic [W-1:0]       cfg_f_stop,
  input  logic [W-1:0]       cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  output logic [W-1:0]       ifreq,
  output logic [W-1:0]       freq,
  output logic               freq_upd,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DWELL  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [1:0] c_MODE_SAW = 2'd1;
  localparam logic [1:0] c_MODE_TRI = 2'd2;

  state_t             r_state, w_state;
  logic               r_dir, w_dir;          // 0 = ramping up, 1 = ramping down
  logic [DWELL_W-1:0] r_cnt, w_cnt;
  logic [W-1:0]       r_f_start, w_f_start;
  logic [W-1:0]       r_f_stop, w_f_stop;
  logic [W-1:0]       r_f_step, w_f_step;
  logic [DWELL_W-1:0] r_dwell, w_dwell;
  logic [1:0]         r_mode, w_mode;
  logic [W-1:0]       w_freq, w_ifreq;
  logic               w_freq_upd, w_busy, w_done, w_err;

  // Both candidate next values are kept one bit wider so carry/borrow show
  // up as the MSB; the triangle turnaround reuses the opposite direction.
  logic [W:0] w_sum, w_diff;
  logic       w_up_end, w_dn_end, w_cfg_bad;

  assign w_sum     = {1'b0, freq} + {1'b0, r_f_step};
  assign w_diff    = {1'b0, freq} - {1'b0, r_f_step};
  assign w_up_end  = w_sum[W]  || (w_sum[W-1:0]  > r_f_stop);
  assign w_dn_end  = w_diff[W] || (w_diff[W-1:0] < r_f_start);
  assign w_cfg_bad = (cfg_f_step == {W{1'b0}}) || (cfg_f_start > cfg_f_stop);

  // State and all outputs/latched configuration are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dir     <= 1'b0;
      r_cnt     <= '0;
      r_f_start <= '0;
      r_f_stop  <= '0;
      r_f_step  <= '0;
      r_dwell   <= '0;
      r_mode    <= '0;
      freq      <= '0;
      ifreq     <= '0;
      freq_upd  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_dir     <= w_dir;
      r_cnt     <= w_cnt;
      r_f_start <= w_f_start;
      r_f_stop  <= w_f_stop;
      r_f_step  <= w_f_step;
      r_dwell   <= w_dwell;
      r_mode    <= w_mode;
      freq      <= w_freq;
      ifreq     <= w_ifreq;
      freq_upd  <= w_freq_upd;
      busy      <= w_busy;
      done      <= w_done;
      err       <= w_err;
    end
  end

  // Next-state and next-output decode; strobes default low every cycle.
  always_comb begin
    w_state    = r_state;
    w_dir      = r_dir;
    w_cnt      = r_cnt;
    w_f_start  = r_f_start;
    w_f_stop   = r_f_stop;
    w_f_step   = r_f_step;
    w_dwell    = r_dwell;
    w_mode     = r_mode;
    w_freq     = freq;
    w_ifreq    = ifreq;
    w_freq_upd = 1'b0;
    w_busy     = busy;
    w_done     = 1'b0;
    w_err      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (abort) begin
          w_state = S_IDLE;
        end else if (start) begin
          if (w_cfg_bad) begin
            w_done = 1'b1;
            w_err  = 1'b1;
          end else begin
            w_f_start  = cfg_f_start;
            w_f_stop   = cfg_f_stop;
            w_f_step   = cfg_f_step;
            w_dwell    = cfg_dwell;
            w_mode     = cfg_mode;
            w_freq     = cfg_f_start;
            w_ifreq    = cfg_ifreq;
            w_freq_upd = 1'b1;
            w_busy     = 1'b1;
            w_dir      = 1'b0;
            w_cnt      = cfg_dwell;
            w_state    = S_DWELL;
          end
        end
      end

      S_DWELL: begin
        if (abort) begin
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else if (r_cnt != {DWELL_W{1'b0}}) begin
          w_cnt = r_cnt - DWELL_W'(1);
        end else if (!r_dir && !w_up_end) begin
          w_freq     = w_sum[W-1:0];
          w_freq_upd = 1'b1;
          w_cnt      = r_dwell;
        end else if (r_dir && !w_dn_end) begin
          w_freq     = w_diff[W-1:0];
          w_freq_upd = 1'b1;
          w_cnt      = r_dwell;
        end else begin
          // End of ramp in the current direction.
          case (r_mode)
            c_MODE_SAW: begin
              w_freq     = r_f_start;
              w_freq_upd = 1'b1;
              w_cnt      = r_dwell;
            end
            c_MODE_TRI: begin
              // Reverse; step back only if that stays inside the window.
              w_dir      = ~r_dir;
              w_freq_upd = 1'b1;
              w_cnt      = r_dwell;
              if (!r_dir) begin
                if (!w_dn_end) w_freq = w_diff[W-1:0];
              end else begin
                if (!w_up_end) w_freq = w_sum[W-1:0];
              end
            end
            default: begin
              w_busy  = 1'b0;
              w_done  = 1'b1;
              w_state = S_FINISH;
            end
          endcase
        end
      end

      S_FINISH: begin
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end

      default: begin
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
